// File: rtl/interp_mac_scheduler.sv
// rtl/interp_mac_scheduler.sv - two-tap linear interpolation MAC scheduler for a shared multiplier
// Optional feature: define INTERP_OVERRUN_CNT_EN to count out_tick strobes dropped while busy.
module interp_mac_scheduler #(
  parameter int MULT_LAT = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic        din_en,
  input  logic [23:0] l_data_in,
  input  logic [23:0] r_data_in,
  input  logic        out_tick,
  output logic        mult_ce,
  output logic [23:0] mult_a,
  output logic [10:0] mult_b,
  input  logic [34:0] mult_p,
  output logic        dout_valid,
  output logic [35:0] l_data_out,
  output logic [35:0] r_data_out,
  output logic [7:0]  overrun_cnt
);

  typedef enum logic [2:0] {IDLE, COEF, ISSUE, DRAIN, DONE} state_t;

  // step counts cycles since the first operand pair was issued; product k returns at step k+LAT
  localparam logic [3:0]  LAT       = 4'(MULT_LAT);
  localparam logic [3:0]  LAST_STEP = 4'(MULT_LAT + 3);
  localparam logic [10:0] CNT_MAX   = 11'd2047;

  state_t      state_q, state_d;
  logic [10:0] cnt_q, cnt_d;
  logic [10:0] pmax_q, pmax_d;
  logic [23:0] l_s0_q, l_s0_d, l_s1_q, l_s1_d;
  logic [23:0] r_s0_q, r_s0_d, r_s1_q, r_s1_d;
  logic [10:0] a_q, a_d, max_q, max_d;
  logic [23:0] sl0_q, sl0_d, sl1_q, sl1_d, sr0_q, sr0_d, sr1_q, sr1_d;
  logic [10:0] c0_q, c0_d, c1_q, c1_d;
  logic [3:0]  step_q, step_d;
  logic [35:0] acc_l_q, acc_l_d, acc_r_q, acc_r_d;
  logic        mult_ce_q, mult_ce_d;
  logic [23:0] mult_a_q, mult_a_d;
  logic [10:0] mult_b_q, mult_b_d;
  logic        dout_valid_q, dout_valid_d;
  logic [35:0] l_out_q, l_out_d, r_out_q, r_out_d;
  logic [10:0] coef0, coef1;
  logic [35:0] p_ext;

  assign p_ext       = {mult_p[34], mult_p};
  assign mult_ce     = mult_ce_q;
  assign mult_a      = mult_a_q;
  assign mult_b      = mult_b_q;
  assign dout_valid  = dout_valid_q;
  assign l_data_out  = l_out_q;
  assign r_data_out  = r_out_q;

  // Period counter and two-deep sample history per channel
  always_comb begin
    cnt_d  = cnt_q;
    pmax_d = pmax_q;
    l_s0_d = l_s0_q;
    l_s1_d = l_s1_q;
    r_s0_d = r_s0_q;
    r_s1_d = r_s1_q;
    if (!run) begin
      cnt_d = 11'd0;
    end else if (din_en) begin
      cnt_d = 11'd0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 11'd1;
    end
    if (din_en) begin
      pmax_d = cnt_q;
      l_s1_d = l_s0_q;
      l_s0_d = l_data_in;
      r_s1_d = r_s0_q;
      r_s0_d = r_data_in;
    end
  end

  // Interpolation weights: distance into the period weights the newest sample
  always_comb begin
    coef0 = a_q;
    coef1 = max_q - a_q;
    if (max_q == 11'd0) begin
      coef0 = 11'd0;
      coef1 = 11'd0;
    end else if (a_q > max_q) begin
      coef0 = max_q;
      coef1 = 11'd0;
    end
  end

  // Sequencer: snapshot, coefficients, four issues, drain, publish
  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    max_d        = max_q;
    sl0_d        = sl0_q;
    sl1_d        = sl1_q;
    sr0_d        = sr0_q;
    sr1_d        = sr1_q;
    c0_d         = c0_q;
    c1_d         = c1_q;
    step_d       = step_q;
    acc_l_d      = acc_l_q;
    acc_r_d      = acc_r_q;
    mult_ce_d    = 1'b0;
    mult_a_d     = mult_a_q;
    mult_b_d     = mult_b_q;
    dout_valid_d = 1'b0;
    l_out_d      = l_out_q;
    r_out_d      = r_out_q;

    case (state_q)
      IDLE: begin
        if (out_tick) begin
          a_d     = cnt_q;
          max_d   = pmax_q;
          sl0_d   = l_s0_q;
          sl1_d   = l_s1_q;
          sr0_d   = r_s0_q;
          sr1_d   = r_s1_q;
          state_d = COEF;
        end
      end
      COEF: begin
        c0_d      = coef0;
        c1_d      = coef1;
        mult_a_d  = sl0_q;
        mult_b_d  = coef0;
        mult_ce_d = 1'b1;
        step_d    = 4'd0;
        state_d   = ISSUE;
      end
      ISSUE: begin
        mult_ce_d = 1'b1;
        step_d    = step_q + 4'd1;
        case (step_q)
          4'd0: begin
            mult_a_d = sl1_q;
            mult_b_d = c1_q;
          end
          4'd1: begin
            mult_a_d = sr0_q;
            mult_b_d = c0_q;
          end
          4'd2: begin
            mult_a_d = sr1_q;
            mult_b_d = c1_q;
          end
          default: state_d = DRAIN;
        endcase
      end
      DRAIN: begin
        mult_ce_d = 1'b1;
        step_d    = step_q + 4'd1;
        if (step_q == LAST_STEP) begin
          mult_ce_d    = 1'b0;
          dout_valid_d = 1'b1;
          l_out_d      = acc_l_q;
          r_out_d      = acc_r_q + p_ext;
          state_d      = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Products return in issue order: L s0, L s1, R s0, R s1
    if (state_q == ISSUE || state_q == DRAIN) begin
      if (step_q == LAT) begin
        acc_l_d = p_ext;
      end else if (step_q == LAT + 4'd1) begin
        acc_l_d = acc_l_q + p_ext;
      end else if (step_q == LAT + 4'd2) begin
        acc_r_d = p_ext;
      end
    end

    // run low abandons the sequence; published results stay as they were
    if (!run) begin
      state_d      = IDLE;
      mult_ce_d    = 1'b0;
      dout_valid_d = 1'b0;
      l_out_d      = l_out_q;
      r_out_d      = r_out_q;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= 11'd0;
      pmax_q       <= 11'd0;
      l_s0_q       <= 24'd0;
      l_s1_q       <= 24'd0;
      r_s0_q       <= 24'd0;
      r_s1_q       <= 24'd0;
      a_q          <= 11'd0;
      max_q        <= 11'd0;
      sl0_q        <= 24'd0;
      sl1_q        <= 24'd0;
      sr0_q        <= 24'd0;
      sr1_q        <= 24'd0;
      c0_q         <= 11'd0;
      c1_q         <= 11'd0;
      step_q       <= 4'd0;
      acc_l_q      <= 36'd0;
      acc_r_q      <= 36'd0;
      mult_ce_q    <= 1'b0;
      mult_a_q     <= 24'd0;
      mult_b_q     <= 11'd0;
      dout_valid_q <= 1'b0;
      l_out_q      <= 36'd0;
      r_out_q      <= 36'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pmax_q       <= pmax_d;
      l_s0_q       <= l_s0_d;
      l_s1_q       <= l_s1_d;
      r_s0_q       <= r_s0_d;
      r_s1_q       <= r_s1_d;
      a_q          <= a_d;
      max_q        <= max_d;
      sl0_q        <= sl0_d;
      sl1_q        <= sl1_d;
      sr0_q        <= sr0_d;
      sr1_q        <= sr1_d;
      c0_q         <= c0_d;
      c1_q         <= c1_d;
      step_q       <= step_d;
      acc_l_q      <= acc_l_d;
      acc_r_q      <= acc_r_d;
      mult_ce_q    <= mult_ce_d;
      mult_a_q     <= mult_a_d;
      mult_b_q     <= mult_b_d;
      dout_valid_q <= dout_valid_d;
      l_out_q      <= l_out_d;
      r_out_q      <= r_out_d;
    end
  end

`ifdef INTERP_OVERRUN_CNT_EN
  logic [7:0] ovr_q, ovr_d;

  // Saturating count of output ticks that arrive while a sequence is in flight
  always_comb begin
    ovr_d = ovr_q;
    if (run && out_tick && state_q != IDLE && ovr_q != 8'hFF) begin
      ovr_d = ovr_q + 8'd1;
    end
  end

  // Overrun counter register, cleared only by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      ovr_q <= 8'd0;
    end else begin
      ovr_q <= ovr_d;
    end
  end

  assign overrun_cnt = ovr_q;
`else
  assign overrun_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_interp_mac_scheduler.sv
// tb/tb_interp_mac_scheduler.sv - scoreboard bench with reference interpolation model
module tb_interp_mac_scheduler;

  localparam int L = 3;
`ifdef INTERP_OVERRUN_CNT_EN
  localparam bit OVR_ON = 1'b1;
`else
  localparam bit OVR_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic        din_en = 1'b0;
  logic [23:0] l_data_in = '0;
  logic [23:0] r_data_in = '0;
  logic        out_tick = 1'b0;
  logic        mult_ce;
  logic [23:0] mult_a;
  logic [10:0] mult_b;
  logic [34:0] mult_p;
  logic        dout_valid;
  logic [35:0] l_data_out;
  logic [35:0] r_data_out;
  logic [7:0]  overrun_cnt;

  interp_mac_scheduler #(.MULT_LAT(L)) dut (
    .clk(clk), .reset(reset), .run(run), .din_en(din_en),
    .l_data_in(l_data_in), .r_data_in(r_data_in), .out_tick(out_tick),
    .mult_ce(mult_ce), .mult_a(mult_a), .mult_b(mult_b), .mult_p(mult_p),
    .dout_valid(dout_valid), .l_data_out(l_data_out), .r_data_out(r_data_out),
    .overrun_cnt(overrun_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural clock-enabled multiplier pipeline
  logic signed [34:0] pipe [L];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < L; i++) pipe[i] <= '0;
    end else if (mult_ce) begin
      pipe[0] <= 35'($signed(mult_a) * $signed({1'b0, mult_b}));
      for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign mult_p = pipe[L-1];

  int total = 0;
  int bad = 0;
  int cyc = 0;

  // Reference model state: values visible before the next clock edge
  int     m_cnt = 0;
  int     m_pmax = 0;
  longint ms0 [2];
  longint ms1 [2];
  int     m_busy = 0;
  int     m_ovr = 0;
  longint exp_l [$];
  longint exp_r [$];
  int     exp_due [$];
  longint last_l = 0;
  longint last_r = 0;

  task automatic chk(input string name, input longint act, input longint expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic model_step(input bit rst, input bit rn, input bit din, input int l, input int r, input bit tick);
    longint a, mx, c0, c1;
    bit idle;
    int old_cnt;
    if (rst) begin
      m_cnt = 0; m_pmax = 0; m_busy = 0; m_ovr = 0;
      ms0[0] = 0; ms0[1] = 0; ms1[0] = 0; ms1[1] = 0;
      exp_l.delete(); exp_r.delete(); exp_due.delete();
      last_l = 0; last_r = 0;
      return;
    end
    idle = (m_busy == 0);
    if (m_busy > 0) m_busy--;
    if (!rn) begin
      if (exp_due.size() > 0 && exp_due[$] > cyc) begin
        void'(exp_l.pop_back()); void'(exp_r.pop_back()); void'(exp_due.pop_back());
      end
      m_busy = 0;
    end else if (tick) begin
      if (idle) begin
        a = m_cnt; mx = m_pmax;
        if (mx == 0) begin c0 = 0; c1 = 0; end
        else if (a > mx) begin c0 = mx; c1 = 0; end
        else begin c0 = a; c1 = mx - a; end
        exp_l.push_back(ms1[0] * c1 + ms0[0] * c0);
        exp_r.push_back(ms1[1] * c1 + ms0[1] * c0);
        exp_due.push_back(cyc + 6 + L);
        m_busy = 6 + L;
      end else if (OVR_ON && m_ovr < 255) begin
        m_ovr++;
      end
    end
    old_cnt = m_cnt;
    if (!rn || din) m_cnt = 0;
    else if (m_cnt < 2047) m_cnt++;
    if (din) begin
      m_pmax = old_cnt;
      ms1[0] = ms0[0]; ms0[0] = l;
      ms1[1] = ms0[1]; ms0[1] = r;
    end
  endtask

  task automatic cyc1(input bit rst, input bit rn, input bit din, input int l, input int r, input bit tick);
    @(negedge clk);
    reset = rst; run = rn; din_en = din; out_tick = tick;
    l_data_in = l[23:0]; r_data_in = r[23:0];
    model_step(rst, rn, din, l, r, tick);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc1(1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic din(input int l, input int r);
    cyc1(1'b0, 1'b1, 1'b1, l, r, 1'b0);
  endtask

  task automatic tick();
    cyc1(1'b0, 1'b1, 1'b0, 0, 0, 1'b1);
  endtask

  task automatic tick_at(input int target);
    for (int k = 0; k < 5000 && m_cnt != target; k++) idle(1);
    tick();
  endtask

  function automatic int rnd_sample();
    return int'($urandom_range(0, 32'h00FF_FFFF)) - 8388608;
  endfunction

  // Monitor: every published result must match the oldest expectation, on time
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (dout_valid) begin
        if (exp_l.size() == 0) begin
          chk("spurious_dout_valid", 1, 0);
        end else begin
          chk("l_data_out", longint'($signed(l_data_out)), exp_l[0]);
          chk("r_data_out", longint'($signed(r_data_out)), exp_r[0]);
          chk("latency_cycle", cyc, exp_due[0]);
          chk("mult_ce_in_done", mult_ce, 0);
          last_l = exp_l.pop_front();
          last_r = exp_r.pop_front();
          void'(exp_due.pop_front());
        end
      end
    end
  end

  initial begin
    int r0;
    for (int i = 0; i < 3; i++) cyc1(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
    idle(1);
    chk("rst_l_out", l_data_out, 0);
    chk("rst_r_out", r_data_out, 0);
    chk("rst_mult_ce", mult_ce, 0);
    chk("rst_mult_a", mult_a, 0);
    chk("rst_mult_b", mult_b, 0);
    chk("rst_dout_valid", dout_valid, 0);
    chk("rst_overrun", overrun_cnt, 0);

    // Constant input, 512-cycle period, tick mid-period
    din(24'h100000, 24'h100000);
    idle(512);
    din(24'h100000, 24'h100000);
    tick_at(128);
    idle(20);
    chk("const_l", longint'($signed(l_data_out)), 64'h2000_0000);
    chk("const_r", longint'($signed(r_data_out)), 64'h2000_0000);

    // Ramp on L, negative ramp on R
    din(0, -1000);
    idle(512);
    din(1000, 0);
    tick_at(256);
    idle(20);
    chk("ramp_l", longint'($signed(l_data_out)), 256000);
    chk("ramp_r", longint'($signed(r_data_out)), -256000);

    // Stalled input: position beyond period clamps to newest sample
    tick_at(700);
    idle(20);
    chk("clamp_l", longint'($signed(l_data_out)), 512000);
    chk("clamp_r", longint'($signed(r_data_out)), 0);

    // Second tick while busy is dropped
    tick();
    idle(3);
    tick();
    idle(20);
    chk("overrun_after_double_tick", overrun_cnt, OVR_ON ? 1 : 0);

    // Abort during ISSUE
    tick();
    idle(3);
    cyc1(1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    idle(1);
    chk("abort_mult_ce", mult_ce, 0);
    idle(20);
    chk("abort_hold_l", longint'($signed(l_data_out)), last_l);
    chk("abort_hold_r", longint'($signed(r_data_out)), last_r);

    // Saturated counter with a short period
    din(3000, -7);
    idle(99);
    din(-5000, 123);
    idle(2100);
    tick();
    idle(20);

    // Reset mid-sequence
    tick();
    idle(4);
    cyc1(1'b1, 1'b1, 1'b0, 0, 0, 1'b0);
    cyc1(1'b1, 1'b1, 1'b0, 0, 0, 1'b0);
    idle(1);
    chk("midrst_l_out", l_data_out, 0);
    chk("midrst_r_out", r_data_out, 0);
    chk("midrst_mult_ce", mult_ce, 0);
    chk("midrst_overrun", overrun_cnt, 0);
    idle(30);

    // Randomized traffic
    for (int i = 0; i < 5000; i++) begin
      r0 = int'($urandom_range(0, 999));
      if (r0 < 2) cyc1(1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
      else if (r0 < 10) cyc1(1'b0, 1'b1, 1'b1, rnd_sample(), rnd_sample(), r0 < 5);
      else if (r0 < 90) tick();
      else idle(1);
    end
    idle(30);
    chk("queue_drained", exp_l.size(), 0);
    chk("final_overrun", overrun_cnt, m_ovr);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/interp_mac_scheduler.md
INTERP_MAC_SCHEDULER -- requirements
Module: interp_mac_scheduler

Interface
REQ-001 Parameter MULT_LAT, 3, latency in clk cycles of the external multiplier from mult_ce-qualified operands to mult_p; legal range 1-8.
REQ-002 clk  input  1  system clock (49.152 MHz mclk domain); all logic on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 run  input  1  enable; low aborts any sequence and holds the block idle.
REQ-005 din_en  input  1  one-cycle strobe marking a new input sample pair.
REQ-006 l_data_in, r_data_in  input  24 each  signed input samples, valid with din_en.
REQ-007 out_tick  input  1  one-cycle 96 kHz output-sample strobe.
REQ-008 mult_ce  output  1  multiplier clock enable.
REQ-009 mult_a  output  24  signed sample operand.
REQ-010 mult_b  output  11  unsigned coefficient operand.
REQ-011 mult_p  input  35  signed product, valid MULT_LAT cycles after its operands were issued.
REQ-012 dout_valid  output  1  one-cycle pulse: outputs updated.
REQ-013 l_data_out, r_data_out  output  36 each  signed interpolated results, unnormalised (scaled by period).
REQ-014 overrun_cnt  output  8  count of out_tick strobes dropped while busy.

Function
REQ-015 Period counter cnt (11 bit) SHALL increment every cycle while run is high, saturate at 2047, clear to 0 on din_en.
REQ-016 On din_en, period_max SHALL load cnt; s1 SHALL load s0 and s0 SHALL load the new sample, per channel.
REQ-017 States SHALL be IDLE, COEF, ISSUE (4 cycles), DRAIN, DONE.
REQ-018 IDLE + out_tick: snapshot a=cnt, max=period_max, s0/s1 of both channels; go to COEF; values are pre-update if din_en coincides.
REQ-019 COEF: c0=a, c1=max-a; if a>max then c0=max, c1=0; if max=0 both coefficients 0.
REQ-020 ISSUE SHALL present one operand pair per cycle with mult_ce high, order: (L s0,c0), (L s1,c1), (R s0,c0), (R s1,c1).
REQ-021 DRAIN: mult_ce held high until the fourth product has returned; then DONE.
REQ-022 Result = s1*c1 + s0*c0 per channel, sign-extended to 36 bits, no rounding or saturation.
REQ-023 DONE SHALL update l_data_out/r_data_out and pulse dout_valid for exactly one cycle, then IDLE.
REQ-024 Latency out_tick to dout_valid SHALL be 6+MULT_LAT cycles (9 at default).
REQ-025 out_tick outside IDLE SHALL be ignored (no queueing).
REQ-026 mult_ce SHALL be low in IDLE and DONE; mult_a/mult_b hold their last values when mult_ce is low.
REQ-027 run low SHALL force IDLE next cycle, clear cnt, drop mult_ce, suppress dout_valid; data outputs hold.

Reset
REQ-028 reset SHALL force state IDLE, cnt=0, period_max=0, s0=s1=0, mult_ce=0, mult_a=0, mult_b=0, dout_valid=0, l_data_out=r_data_out=0, overrun_cnt=0.
REQ-029 reset mid-sequence SHALL abort it with no dout_valid pulse and no late product accepted.

Configuration
REQ-030 With INTERP_OVERRUN_CNT_EN defined, overrun_cnt SHALL increment (saturating at 255) on each out_tick ignored per REQ-025, clearing only on reset.
REQ-031 Without INTERP_OVERRUN_CNT_EN, overrun_cnt SHALL be constant 0 and no counter logic synthesised.

Verification (MULT_LAT=3, behavioural multiplier model)
REQ-032 reset high 2 cycles mid-activity -> all outputs 0, mult_ce 0, no dout_valid afterwards until a new out_tick.
REQ-033 din_en every 512 cycles, L=R=0x100000 constant, out_tick at cnt=128 -> c0=128, c1=384, both outputs 0x20000000, dout_valid exactly 9 cycles after out_tick.
REQ-034 L s1=0, s0=1000, period 512, out_tick at cnt=256 -> l_data_out=256000; R s1=-1000, s0=0 -> r_data_out=-256000.
REQ-035 din_en stalled, out_tick at cnt=700 with period_max=512 -> c0=512, c1=0, l_data_out=s0*512.
REQ-036 second out_tick 4 cycles after first -> single dout_valid; overrun_cnt=1 with macro, 0 without.
REQ-037 run deasserted during ISSUE -> mult_ce low next cycle, no dout_valid, outputs retain previous values.
